qtree_int_serializer: RTL and testbench

QTREE_INT_SERIALIZER -- requirements
Module: qtree_int_serializer

---
 rtl/qtree_int_serializer.sv | 207 ++++++++++++++++++++
 tb/tb_qtree_int_serializer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qtree_int_serializer.sv
// qtree_int_serializer
// Walks a quad-tree of Int leaves stored in a word-addressed heap and streams
// it out in postorder (child3, child2, child1, child0, node). Node words carry
// no pointers; the receiver rebuilds the tree from the postorder stream.
//
// state | meaning
// IDLE  | waiting for a root pointer (root_r high once out of reset)
// REQ   | heap read request for the current pointer held on rd_valid
// WAIT  | read accepted, waiting for the single response pulse
// EMIT  | stream word held on tvalid until tready
// NEXT  | pick the next child from the stack top, or pop and emit the node
module qtree_int_serializer #(
  parameter int PTR_W       = 16,
  parameter int INT_W       = 32,
  parameter int STACK_DEPTH = 64
) (
  input  logic             clk,
  input  logic             aresetn,
  input  logic [PTR_W:0]   root_d,
  output logic             root_r,
  output logic [PTR_W-1:0] rd_addr,
  output logic             rd_valid,
  input  logic             rd_ready,
  input  logic [65:0]      rd_data,
  input  logic             rd_data_valid,
  output logic [66:0]      o_QTree_Int_tdata,
  output logic             o_QTree_Int_tvalid,
  input  logic             o_QTree_Int_tready,
  output logic             o_QTree_Int_tlast,
  output logic             ovf
);

  // Child pointers occupy fixed 16-bit fields of the heap word and leaf values
  // must fit in the 64-bit payload above the tag.
  if (PTR_W < 1 || PTR_W > 16 || INT_W < 1 || INT_W > 64 || STACK_DEPTH < 1) begin : g_bad_param
    $error("qtree_int_serializer: unsupported parameter set");
  end

  localparam int SP_W = $clog2(STACK_DEPTH + 1);
  localparam int AW   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  localparam logic [1:0]  TAG_NODE  = 2'd2;
  localparam logic [66:0] NODE_WORD = {64'd0, 2'd2, 1'b0};
  localparam logic [66:0] ERR_WORD  = {64'd0, 2'd3, 1'b0};

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    EMIT = 3'd3,
    NEXT = 3'd4
  } state_t;

  state_t state, state_nxt;

  logic [SP_W-1:0]    sp;
  logic [PTR_W-1:0]   cur, cur_nxt;
  logic [66:0]        tdata_q, out_nxt;
  logic               tlast_q, last_nxt;
  logic               root_ok;

  // Traversal stack: four child pointers plus the index of the child in flight
  logic [4*PTR_W-1:0] stk_kids [STACK_DEPTH];
  logic [1:0]         stk_idx  [STACK_DEPTH];

  logic               root_acc;
  logic               push, pop, dec, clr, ld_cur, ld_out, set_ovf;
  logic               stk_empty, stk_full;
  logic [AW-1:0]      top, sp_a;
  logic [1:0]         top_idx, sel;
  logic [PTR_W-1:0]   sel_child;
  logic [4*PTR_W-1:0] new_kids;

  assign root_r   = root_ok && (state == IDLE);
  assign root_acc = root_r && root_d[0];

  assign rd_valid = (state == REQ);
  assign rd_addr  = cur;

  assign o_QTree_Int_tvalid = (state == EMIT);
  assign o_QTree_Int_tdata  = tdata_q;
  assign o_QTree_Int_tlast  = tlast_q;

  assign stk_empty = (sp == '0);
  assign stk_full  = (sp == SP_W'(STACK_DEPTH));
  assign top       = AW'(sp - SP_W'(1));
  assign sp_a      = AW'(sp);
  assign top_idx   = stk_idx[top];
  assign sel       = top_idx - 2'd1;
  assign sel_child = stk_kids[top][int'(sel)*PTR_W +: PTR_W];
  assign new_kids  = {PTR_W'(rd_data[65:50]), PTR_W'(rd_data[49:34]),
                      PTR_W'(rd_data[33:18]), PTR_W'(rd_data[17:2])};

  // State register
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state and datapath control
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    pop       = 1'b0;
    dec       = 1'b0;
    clr       = 1'b0;
    ld_cur    = 1'b0;
    cur_nxt   = cur;
    ld_out    = 1'b0;
    out_nxt   = tdata_q;
    last_nxt  = tlast_q;
    set_ovf   = 1'b0;
    unique case (state)
      IDLE: begin
        if (root_acc) begin
          ld_cur    = 1'b1;
          cur_nxt   = root_d[PTR_W:1];
          state_nxt = REQ;
        end
      end
      REQ: begin
        if (rd_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (rd_data_valid) begin
          if (rd_data[1:0] == TAG_NODE) begin
            if (stk_full) begin
              // No room to descend: drop the tree and close the frame with an error word
              set_ovf   = 1'b1;
              clr       = 1'b1;
              ld_out    = 1'b1;
              out_nxt   = ERR_WORD;
              last_nxt  = 1'b1;
              state_nxt = EMIT;
            end else begin
              push      = 1'b1;
              ld_cur    = 1'b1;
              cur_nxt   = PTR_W'(rd_data[65:50]);
              state_nxt = REQ;
            end
          end else begin
            ld_out    = 1'b1;
            out_nxt   = {rd_data, 1'b0};
            last_nxt  = stk_empty;
            state_nxt = EMIT;
          end
        end
      end
      EMIT: begin
        if (o_QTree_Int_tready) state_nxt = NEXT;
      end
      NEXT: begin
        if (stk_empty) begin
          state_nxt = IDLE;
        end else if (top_idx != 2'd0) begin
          dec       = 1'b1;
          ld_cur    = 1'b1;
          cur_nxt   = sel_child;
          state_nxt = REQ;
        end else begin
          // All four children sent: the node itself follows them
          pop       = 1'b1;
          ld_out    = 1'b1;
          out_nxt   = NODE_WORD;
          last_nxt  = (sp == SP_W'(1));
          state_nxt = EMIT;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Pointer, output word, stack pointer and sticky overflow
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      sp      <= '0;
      cur     <= '0;
      tdata_q <= '0;
      tlast_q <= 1'b0;
      ovf     <= 1'b0;
      root_ok <= 1'b0;
    end else begin
      root_ok <= 1'b1;
      if (ld_cur) cur <= cur_nxt;
      if (ld_out) begin
        tdata_q <= out_nxt;
        tlast_q <= last_nxt;
      end
      if (clr)       sp <= '0;
      else if (push) sp <= sp + SP_W'(1);
      else if (pop)  sp <= sp - SP_W'(1);
      if (root_acc)     ovf <= 1'b0;
      else if (set_ovf) ovf <= 1'b1;
    end
  end

  // Stack storage; contents above sp are don't-care so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      stk_kids[sp_a] <= new_kids;
      stk_idx[sp_a]  <= 2'd3;
    end else if (dec) begin
      stk_idx[top] <= top_idx - 2'd1;
    end
  end

endmodule

// File: tb/tb_qtree_int_serializer.sv
module tb_qtree_int_serializer;

  localparam int SD = 2;

  logic        clk = 1'b0;
  logic        aresetn;
  logic [16:0] root_d;
  logic        root_r;
  logic [15:0] rd_addr;
  logic        rd_valid;
  logic        rd_ready;
  logic [65:0] rd_data;
  logic        rd_data_valid;
  logic [66:0] tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic        ovf;

  qtree_int_serializer #(.PTR_W(16), .INT_W(32), .STACK_DEPTH(SD)) dut (
    .clk(clk), .aresetn(aresetn),
    .root_d(root_d), .root_r(root_r),
    .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid),
    .o_QTree_Int_tdata(tdata), .o_QTree_Int_tvalid(tvalid),
    .o_QTree_Int_tready(tready), .o_QTree_Int_tlast(tlast),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  logic [65:0] heap [int];
  logic [66:0] exp_q [$];
  int          exp_rd [$];
  bit          ovf_hit;

  int  tr_mode = 0;
  bit  stall = 0;
  int  lat_lo = 1, lat_hi = 1;
  int  ready_limit = 1 << 30;
  int  beats_seen = 0;
  bit  chk_en = 0;
  bit  pending = 0;

  localparam logic [65:0] JUNK = {32'd0, 32'hBAD, 2'd1};

  task automatic chk(input string name, input logic [66:0] act, input logic [66:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s actual=%h required=%h", name, act, req);
  endtask

  function automatic logic [65:0] mk_val(input int v);
    return {32'd0, 32'(v), 2'd1};
  endfunction

  function automatic logic [65:0] mk_node(input int c0, input int c1, input int c2, input int c3);
    return {16'(c3), 16'(c2), 16'(c1), 16'(c0), 2'd2};
  endfunction

  // Postorder walk of the heap with a bounded number of open nodes
  function automatic void visit(input int addr, input int depth);
    logic [65:0] w;
    if (ovf_hit) return;
    w = heap[addr];
    exp_rd.push_back(addr);
    if (w[1:0] == 2'd2) begin
      if (depth == SD) begin
        ovf_hit = 1;
        exp_q.push_back({64'd0, 2'd3, 1'b0});
        return;
      end
      for (int k = 3; k >= 0; k--) begin
        visit(int'(w[2 + 16*k +: 16]), depth + 1);
        if (ovf_hit) return;
      end
      exp_q.push_back({64'd0, 2'd2, 1'b0});
    end else begin
      exp_q.push_back({w, 1'b0});
    end
  endfunction

  function automatic void build(input int root);
    exp_q.delete();
    exp_rd.delete();
    ovf_hit = 0;
    visit(root, 0);
  endfunction

  // Heap responder: one response per accepted read after a configurable latency
  initial begin
    bit hs;
    bit resp;
    int hs_addr, paddr, cnt;
    rd_data_valid = 1'b0;
    rd_data = JUNK;
    rd_ready = 1'b1;
    tready = 1'b1;
    cnt = 0;
    paddr = 0;
    forever begin
      @(negedge clk);
      hs = rd_valid && rd_ready && aresetn;
      hs_addr = int'(rd_addr);
      @(posedge clk);
      #1;
      rd_data_valid = 1'b0;
      rd_data = JUNK;
      resp = 0;
      if (!aresetn) begin
        pending = 0;
        cnt = 0;
      end else begin
        if (pending) begin
          cnt--;
          if (cnt <= 0) begin
            rd_data = heap[paddr];
            rd_data_valid = 1'b1;
            pending = 0;
            resp = 1;
          end
        end
        if (hs) begin
          pending = 1;
          paddr = hs_addr;
          cnt = int'($urandom_range(lat_hi, lat_lo));
        end else if (!pending && !resp && stall && $urandom_range(0, 3) == 0) begin
          rd_data_valid = 1'b1;
        end
      end
      rd_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      case (tr_mode)
        1:       tready = ~tready;
        2:       tready = ($urandom_range(0, 1) == 1);
        default: tready = 1'b1;
      endcase
      if (beats_seen >= ready_limit) tready = 1'b0;
    end
  end

  // Compare process: reads, beats, tlast and hold stability against the model
  initial begin
    bit held_v = 0;
    logic [66:0] held_d;
    logic held_l;
    forever begin
      @(negedge clk);
      if (!aresetn) begin
        held_v = 0;
      end else if (chk_en) begin
        if (rd_valid && pending) chk("one_outstanding", 1, 0);
        if (rd_valid && rd_ready) begin
          if (exp_rd.size() == 0) chk("rd_unexpected", 67'(rd_addr), 0);
          else chk("rd_addr", 67'(rd_addr), 67'(exp_rd.pop_front()));
        end
        if (held_v && tvalid) begin
          chk("hold_tdata", tdata, held_d);
          chk("hold_tlast", 67'(tlast), 67'(held_l));
        end
        held_v = tvalid && !tready;
        held_d = tdata;
        held_l = tlast;
        if (tvalid && tready) begin
          beats_seen++;
          if (exp_q.size() == 0) chk("beat_unexpected", tdata, 0);
          else begin
            chk("tlast", 67'(tlast), 67'(exp_q.size() == 1));
            chk("tdata", tdata, exp_q.pop_front());
          end
        end
      end
    end
  end

  task automatic start_root(input int root);
    int n = 0;
    while (!root_r && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("root_r_wait", 67'(root_r), 1);
    root_d = {16'(root), 1'b1};
    @(posedge clk);
    #1 root_d = '0;
  endtask

  task automatic run_tree(input int root);
    int n = 0;
    start_root(root);
    @(negedge clk);
    while (!(exp_q.size() == 0 && root_r) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("tree_done", 67'(n < 3000), 1);
    chk("reads_left", 67'(exp_rd.size()), 0);
  endtask

  initial begin
    logic [66:0] lit2 [5];
    int rd2 [5];
    int n;
    lit2 = '{67'h142, 67'hF2, 67'hA2, 67'h52, 67'h4};
    rd2  = '{1, 5, 4, 3, 2};

    heap[1]  = mk_node(2, 3, 4, 5);
    heap[2]  = mk_val(10);
    heap[3]  = mk_val(20);
    heap[4]  = mk_val(30);
    heap[5]  = mk_val(40);
    heap[6]  = mk_val(5);
    heap[10] = mk_node(6, 6, 6, 11);
    heap[11] = mk_node(6, 6, 6, 12);
    heap[12] = mk_node(6, 6, 6, 13);
    heap[13] = mk_val(7);
    heap[20] = mk_node(6, 2, 3, 21);
    heap[21] = mk_node(2, 3, 4, 5);
    heap[30] = {64'd0, 2'd0};
    heap[31] = {64'h1234, 2'd3};

    aresetn = 1'b0;
    root_d = '0;
    repeat (3) @(negedge clk);
    chk("rst_root_r", 67'(root_r), 0);
    chk("rst_rd_valid", 67'(rd_valid), 0);
    chk("rst_rd_addr", 67'(rd_addr), 0);
    chk("rst_tvalid", 67'(tvalid), 0);
    chk("rst_tlast", 67'(tlast), 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_ovf", 67'(ovf), 0);
    aresetn = 1'b1;
    @(posedge clk);
    #1 chk("root_r_after_release", 67'(root_r), 1);
    chk_en = 1;

    // Single leaf at address 6 holding QVal 5
    build(6);
    chk("model_leaf_n", 67'(exp_q.size()), 1);
    chk("model_leaf", exp_q[0], 67'h2A);
    run_tree(6);
    chk("ovf_leaf", 67'(ovf), 0);

    // One node with four leaves
    build(1);
    chk("model_node_n", 67'(exp_q.size()), 5);
    for (int i = 0; i < 5; i++) chk("model_node_word", exp_q[i], lit2[i]);
    for (int i = 0; i < 5; i++) chk("model_node_rd", 67'(exp_rd[i]), 67'(rd2[i]));
    run_tree(1);

    // QNone and QError leaves pass through untouched
    build(30);
    run_tree(30);
    build(31);
    run_tree(31);

    // tready toggling every cycle
    tr_mode = 1;
    build(1);
    run_tree(1);

    // Random stalls, latencies 1-8 and stray response pulses
    tr_mode = 2;
    stall = 1;
    lat_lo = 1;
    lat_hi = 8;
    for (int r = 0; r < 3; r++) begin
      build(1);
      run_tree(1);
    end
    tr_mode = 0;
    stall = 0;
    lat_lo = 1;
    lat_hi = 1;

    // Nesting exactly as deep as the stack
    build(20);
    run_tree(20);
    chk("ovf_full_depth", 67'(ovf), 0);

    // One level too deep
    build(10);
    chk("model_ovf_n", 67'(exp_q.size()), 1);
    chk("model_ovf_word", exp_q[0], 67'h6);
    chk("model_ovf_rd", 67'(exp_rd.size()), 3);
    run_tree(10);
    chk("ovf_set", 67'(ovf), 1);
    build(6);
    run_tree(6);
    chk("ovf_cleared", 67'(ovf), 0);

    // Reset while beat 2 is on the stream
    build(1);
    ready_limit = beats_seen + 1;
    start_root(1);
    n = 0;
    while (!(beats_seen == ready_limit && tvalid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("beat2_reached", 67'(n < 500), 1);
    #2 aresetn = 1'b0;
    #1;
    chk("midrst_tvalid", 67'(tvalid), 0);
    chk("midrst_rd_valid", 67'(rd_valid), 0);
    chk("midrst_root_r", 67'(root_r), 0);
    exp_q.delete();
    exp_rd.delete();
    ready_limit = 1 << 30;
    @(negedge clk);
    @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk);
    #1 chk("midrst_root_r_back", 67'(root_r), 1);
    build(1);
    run_tree(1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
